// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared types and FP16 ordering helper for the FC result streamer
package fc_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    // Maps an FP16 bit pattern onto an unsigned key whose order matches numeric order (-0 < +0).
    function automatic logic [15:0] fp16_order_key(input logic [15:0] x);
        return x[15] ? ~x : (x ^ 16'h8000);
    endfunction

endpackage

// File: rtl/fp16_argmax_tracker.sv
// rtl/fp16_argmax_tracker.sv - running argmax over a word-serial FP16 stream
module fp16_argmax_tracker
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int IDX_W      = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  update,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [IDX_W-1:0]      index,
    output logic [IDX_W-1:0]      max_index
);

    logic [15:0]      best_key;
    logic [IDX_W-1:0] best_index;
    logic [15:0]      key;
    logic             take;

    // Key 0 with index 0 is a safe empty state: element 0 either beats it or ties and keeps index 0.
    assign key       = fp16_order_key(data);
    assign take      = update && (key > best_key);
    assign max_index = take ? index : best_index;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            best_key   <= '0;
            best_index <= '0;
        end else if (clear) begin
            best_key   <= '0;
            best_index <= '0;
        end else if (take) begin
            best_key   <= key;
            best_index <= index;
        end
    end

endmodule

// File: rtl/fc_result_streamer.sv
// rtl/fc_result_streamer.sv - snapshots an FC result bus and streams it word-serially with argmax
module fc_result_streamer
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int output_channel = 84,
    parameter int IDX_W          = $clog2(output_channel)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [output_channel*DATA_WIDTH-1:0] outputConv,
    input  logic                               capture,
    input  logic                               out_ready,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic                               out_valid,
    output logic [IDX_W-1:0]                   out_index,
    output logic                               out_last,
    output logic                               busy,
    output logic                               overrun,
    output logic [IDX_W-1:0]                   max_index,
    output logic                               max_valid
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(output_channel - 1);

    state_t                state;
    logic [DATA_WIDTH-1:0] snap [output_channel];
    logic [IDX_W-1:0]      index;
    logic [IDX_W-1:0]      frame_max;
    logic                  at_last;
    logic                  xfer;
    logic                  accept;

    assign at_last   = (index == LAST_IDX);
    assign out_valid = (state == STREAM);
    assign busy      = (state == STREAM);
    assign xfer      = out_valid && out_ready;
    // A capture coinciding with the final transfer is accepted as the next frame, not an overrun.
    assign accept    = capture && ((state == IDLE) || (xfer && at_last));

    assign out_index = index;
    assign out_data  = out_valid ? snap[index] : '0;
    assign out_last  = out_valid && at_last;

    fp16_argmax_tracker #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_argmax (
        .clk       (clk),
        .reset     (reset),
        .clear     (accept),
        .update    (xfer),
        .data      (out_data),
        .index     (index),
        .max_index (frame_max)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            index     <= '0;
            overrun   <= 1'b0;
            max_index <= '0;
            max_valid <= 1'b0;
            for (int i = 0; i < output_channel; i++) begin
                snap[i] <= '0;
            end
        end else begin
            if (accept) begin
                for (int i = 0; i < output_channel; i++) begin
                    snap[i] <= outputConv[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            case (state)
                IDLE: begin
                    if (capture) begin
                        index     <= '0;
                        max_valid <= 1'b0;
                        overrun   <= 1'b0;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (capture && !accept) begin
                        overrun <= 1'b1;
                    end
                    if (xfer) begin
                        if (at_last) begin
                            max_index <= frame_max;
                            max_valid <= 1'b1;
                            index     <= '0;
                            if (capture) begin
                                overrun <= 1'b0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            index <= index + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_result_streamer.sv
// tb/tb_fc_result_streamer.sv - directed table-driven bench for fc_result_streamer
module tb_fc_result_streamer;

    localparam int DW = 16;
    localparam int N  = 84;
    localparam int IW = 7;

    logic            clk = 1'b0;
    logic            reset;
    logic [N*DW-1:0] outputConv;
    logic            capture;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic [IW-1:0]   out_index;
    logic            out_last;
    logic            busy;
    logic            overrun;
    logic [IW-1:0]   max_index;
    logic            max_valid;

    int total = 0;
    int bad   = 0;

    logic [15:0] elem [N];

    typedef struct {
        int          mode;
        logic [15:0] fill;
        int          i1;
        logic [15:0] v1;
        int          i2;
        logic [15:0] v2;
        bit          stall;
        int          exp_max;
    } vec_t;

    vec_t vecs [7];

    fc_result_streamer dut (
        .clk        (clk),
        .reset      (reset),
        .outputConv (outputConv),
        .capture    (capture),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_index  (out_index),
        .out_last   (out_last),
        .busy       (busy),
        .overrun    (overrun),
        .max_index  (max_index),
        .max_valid  (max_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic build(input vec_t v);
        for (int i = 0; i < N; i++) begin
            elem[i] = (v.mode == 0) ? 16'(i) : v.fill;
        end
        if (v.mode != 0) begin
            elem[v.i1] = v.v1;
            elem[v.i2] = v.v2;
        end
    endtask

    task automatic drive_bus();
        for (int i = 0; i < N; i++) begin
            outputConv[i*DW +: DW] = elem[i];
        end
    endtask

    task automatic load_and_capture();
        drive_bus();
        capture = 1'b1;
        @(negedge clk);
        capture    = 1'b0;
        outputConv = ~outputConv;
    endtask

    task automatic check_word(input int k);
        chk("valid", out_valid, 1);
        chk("data", out_data, elem[k]);
        chk("index", out_index, k);
        chk("last", out_last, (k == N - 1));
    endtask

    task automatic stream(input bit stall, input int exp_max, input bit mv_mid);
        int k;
        int cyc;
        k   = 0;
        cyc = 0;
        while (k < N && cyc < 2000) begin
            out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            check_word(k);
            chk("max_valid_mid", max_valid, mv_mid);
            @(negedge clk);
            if (out_ready) k++;
            cyc++;
        end
        out_ready = 1'b0;
        chk("frame_words", k, N);
        if (!stall) chk("frame_cycles", cyc, N);
        chk("busy_end", busy, 0);
        chk("valid_end", out_valid, 0);
        chk("max_valid_end", max_valid, 1);
        chk("max_index_end", max_index, exp_max);
    endtask

    initial begin
        vecs[0] = '{0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1'b0, 83};
        vecs[1] = '{0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1'b1, 83};
        vecs[2] = '{1, 16'hBC00, 17, 16'h3C00, 40, 16'h3C00, 1'b0, 17};
        vecs[3] = '{1, 16'hC000, 5, 16'h8000, 9, 16'h0000, 1'b1, 9};
        vecs[4] = '{1, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1'b0, 0};
        vecs[5] = '{1, 16'h3C00, 83, 16'h7E00, 83, 16'h7E00, 1'b1, 83};
        vecs[6] = '{1, 16'h8001, 60, 16'h8000, 60, 16'h8000, 1'b0, 60};

        reset      = 1'b1;
        capture    = 1'b0;
        out_ready  = 1'b0;
        outputConv = '0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_index", out_index, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_max_index", max_index, 0);
        chk("rst_max_valid", max_valid, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int v = 0; v < 7; v++) begin
            build(vecs[v]);
            load_and_capture();
            chk("busy_start", busy, 1);
            stream(vecs[v].stall, vecs[v].exp_max, 1'b0);
        end

        // overrun mid-frame, then back-to-back capture on the final transfer
        build(vecs[0]);
        load_and_capture();
        out_ready = 1'b1;
        for (int k = 0; k < N - 1; k++) begin
            check_word(k);
            if (k == 30) capture = 1'b1;
            @(negedge clk);
            capture = 1'b0;
            if (k == 29) chk("overrun_before", overrun, 0);
            if (k == 30) chk("overrun_set", overrun, 1);
        end
        check_word(N - 1);
        build(vecs[2]);
        drive_bus();
        capture = 1'b1;
        @(negedge clk);
        capture    = 1'b0;
        outputConv = ~outputConv;
        chk("b2b_busy", busy, 1);
        chk("b2b_index", out_index, 0);
        chk("b2b_data", out_data, elem[0]);
        chk("b2b_overrun", overrun, 0);
        chk("b2b_max_valid", max_valid, 1);
        chk("b2b_max_index", max_index, 83);
        stream(1'b0, 17, 1'b1);

        // asynchronous reset mid-frame
        build(vecs[3]);
        load_and_capture();
        out_ready = 1'b1;
        for (int k = 0; k < 50; k++) begin
            check_word(k);
            @(negedge clk);
        end
        chk("pre_reset_index", out_index, 50);
        #2 reset = 1'b1;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_busy", busy, 0);
        chk("ar_max_valid", max_valid, 0);
        chk("ar_index", out_index, 0);
        chk("ar_data", out_data, 0);
        chk("ar_last", out_last, 0);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b0;
        build(vecs[5]);
        load_and_capture();
        stream(1'b0, 83, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
